// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the floating-point add/subtract pipeline.
package fp_pkg;

  localparam int         EXP_W    = 8;
  localparam int         FRAC_W   = 23;
  localparam int         MANT_W   = 24;
  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         EXP_BIAS = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Stage-1 result carried into the shift stage.
  typedef struct packed {
    logic [MANT_W-1:0] mant_x;
    logic [MANT_W-1:0] mant_y;
    logic [EXP_W-1:0]  exp_x;
    logic [EXP_W-1:0]  diff;
    logic              sel2;
    logic              sign;
    logic              is_inf;
    logic              is_nan;
  } align_s1_t;

  // Mantissa with hidden bit; subnormals flush to zero.
  function automatic logic [MANT_W-1:0] mant_of(input fp32_t x);
    return (x.exp == '0) ? '0 : {1'b1, x.frac};
  endfunction

  // Magnitude key {exp,frac} after flushing subnormals to zero.
  function automatic logic [EXP_W+FRAC_W-1:0] mag_of(input fp32_t x);
    return (x.exp == '0) ? '0 : {x.exp, x.frac};
  endfunction

endpackage

// File: rtl/fp_align_if.sv
// Handshake and data bundle for the fp_align stage.
interface fp_align_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              op;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] non_shifted_val;
  logic [MANT_W-1:0] shifted_val;
  logic [EXP_W-1:0]  exponent_temp;
  logic              sel2;
  logic              sign;
  logic              sticky;
  logic              is_inf;
  logic              is_nan;

  // The alignment stage: consumes operand pairs, produces aligned results.
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, non_shifted_val, shifted_val, exponent_temp,
           sel2, sign, sticky, is_inf, is_nan
  );

  // The environment around the stage: issues operands, accepts results.
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, non_shifted_val, shifted_val, exponent_temp,
           sel2, sign, sticky, is_inf, is_nan
  );

endinterface

// File: rtl/fp_rshift_sticky.sv
// Combinational 24-bit logarithmic right shifter with sticky collection.
// Amounts of 24 or more saturate to zero with sticky = OR of the input.
module fp_rshift_sticky
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] val,
  input  logic [EXP_W-1:0]  amt,
  output logic [MANT_W-1:0] shifted,
  output logic              sticky
);

  logic [MANT_W-1:0] v;
  logic              s;

  // Bits dropped by the shift-by-2^k level.
  function automatic logic [MANT_W-1:0] low_mask(input int k);
    case (k)
      0:       return 24'h000001;
      1:       return 24'h000003;
      2:       return 24'h00000F;
      3:       return 24'h0000FF;
      default: return 24'h00FFFF;
    endcase
  endfunction

  // Five shift levels, each ORing its discarded bits into sticky; then saturate.
  always_comb begin
    v       = val;
    s       = 1'b0;
    shifted = '0;
    sticky  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (amt[k]) begin
        s = s | (|(v & low_mask(k)));
        v = v >> (1 << k);
      end
    end
    if (amt >= 8'd24) begin
      shifted = '0;
      sticky  = |val;
    end else begin
      shifted = v;
      sticky  = s;
    end
  end

endmodule

// File: rtl/fp_align.sv
// Alignment stage of the binary32 add/subtract pipeline: unpack, order by
// magnitude, and right-shift the smaller mantissa. Two registered stages with
// valid/ready flow control and one operation per cycle.
module fp_align
  import fp_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  fp_align_if.slave bus
);

  fp32_t                   ua;
  fp32_t                   ub;
  logic                    sb_eff;
  logic [EXP_W+FRAC_W-1:0] mag_a;
  logic [EXP_W+FRAC_W-1:0] mag_b;
  logic                    a_ge;
  logic                    mag_eq;
  logic                    a_inf;
  logic                    b_inf;
  logic                    a_nan;
  logic                    b_nan;
  logic                    sign_x;
  align_s1_t               s1_d;
  align_s1_t               align_p1;

  logic                    s1_v;
  logic                    s2_v;
  logic                    s1_adv;
  logic                    s2_adv;

  logic [MANT_W-1:0]       sh_val;
  logic                    sh_sticky;

  logic [MANT_W-1:0]       nsv_p2;
  logic [MANT_W-1:0]       sv_p2;
  logic [EXP_W-1:0]        exp_p2;
  logic                    sel2_p2;
  logic                    sign_p2;
  logic                    sticky_p2;
  logic                    inf_p2;
  logic                    nan_p2;

  assign ua     = fp32_t'(bus.a);
  assign ub     = fp32_t'(bus.b);
  assign sb_eff = ub.sign ^ bus.op;
  assign mag_a  = mag_of(ua);
  assign mag_b  = mag_of(ub);
  assign a_ge   = (mag_a >= mag_b);
  assign mag_eq = (mag_a == mag_b);
  assign a_inf  = (ua.exp == EXP_MAX) && (ua.frac == '0);
  assign b_inf  = (ub.exp == EXP_MAX) && (ub.frac == '0);
  assign a_nan  = (ua.exp == EXP_MAX) && (ua.frac != '0);
  assign b_nan  = (ub.exp == EXP_MAX) && (ub.frac != '0);

  // Stage boundaries advance when the next slot is free or being drained.
  assign s2_adv       = !s2_v | bus.out_ready;
  assign s1_adv       = !s1_v | s2_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1 logic: order operands (ties keep A as X), classify specials, pick sign.
  always_comb begin
    s1_d   = '0;
    sign_x = 1'b0;
    if (a_ge) begin
      s1_d.mant_x = mant_of(ua);
      s1_d.mant_y = mant_of(ub);
      s1_d.exp_x  = ua.exp;
      s1_d.diff   = ua.exp - ub.exp;
      sign_x      = ua.sign;
    end else begin
      s1_d.mant_x = mant_of(ub);
      s1_d.mant_y = mant_of(ua);
      s1_d.exp_x  = ub.exp;
      s1_d.diff   = ub.exp - ua.exp;
      sign_x      = sb_eff;
    end
    s1_d.sel2   = ua.sign ^ sb_eff;
    s1_d.is_nan = a_nan | b_nan | (a_inf & b_inf & s1_d.sel2);
    s1_d.is_inf = !s1_d.is_nan & (a_inf | b_inf);
    if (s1_d.is_inf) begin
      s1_d.sign = a_inf ? ua.sign : sb_eff;
    end else if (mag_eq && s1_d.sel2) begin
      s1_d.sign = 1'b0;
    end else begin
      s1_d.sign = sign_x;
    end
  end

  // Stage 1 register: capture the ordered operands on every accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      align_p1 <= '0;
    end else if (s1_adv) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        align_p1 <= s1_d;
      end
    end
  end

  fp_rshift_sticky u_shift (
    .val     (align_p1.mant_y),
    .amt     (align_p1.diff),
    .shifted (sh_val),
    .sticky  (sh_sticky)
  );

  // Stage 2 register: aligned result, held while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v      <= 1'b0;
      nsv_p2    <= '0;
      sv_p2     <= '0;
      exp_p2    <= '0;
      sel2_p2   <= 1'b0;
      sign_p2   <= 1'b0;
      sticky_p2 <= 1'b0;
      inf_p2    <= 1'b0;
      nan_p2    <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        nsv_p2    <= align_p1.mant_x;
        sv_p2     <= sh_val;
        exp_p2    <= align_p1.exp_x;
        sel2_p2   <= align_p1.sel2;
        sign_p2   <= align_p1.sign;
        sticky_p2 <= sh_sticky;
        inf_p2    <= align_p1.is_inf;
        nan_p2    <= align_p1.is_nan;
      end
    end
  end

  assign bus.out_valid       = s2_v;
  assign bus.non_shifted_val = nsv_p2;
  assign bus.shifted_val     = sv_p2;
  assign bus.exponent_temp   = exp_p2;
  assign bus.sel2            = sel2_p2;
  assign bus.sign            = sign_p2;
  assign bus.sticky          = sticky_p2;
  assign bus.is_inf          = inf_p2;
  assign bus.is_nan          = nan_p2;

endmodule
